// File: rtl/seg_pkg.sv
// ============================================================================
// Package : seg_pkg
// Brief   : Widths, saturation limits and FSM encoding for the pitch PID path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int PTCH_W  = 16;
    localparam int ERR_W   = 10;
    localparam int DDIFF_W = 7;
    localparam int INTEG_W = 18;

    localparam int ERR_MAX   = 511;
    localparam int ERR_MIN   = -512;
    localparam int DDIFF_MAX = 63;
    localparam int DDIFF_MIN = -64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAT   = 2'd1,
        INTEG = 2'd2,
        DONE  = 2'd3
    } pid_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_signed.sv
// ============================================================================
// Module  : sat_signed
// Brief   : Combinational signed clamp from IN_W bits down to OUT_W bits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_signed #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10,
    parameter int MAX_V = 2**(OUT_W-1) - 1,
    parameter int MIN_V = -(2**(OUT_W-1))
) (
    input  logic signed [IN_W-1:0]  d_i,
    output logic signed [OUT_W-1:0] q_o
);

    localparam logic signed [IN_W-1:0]  c_hi_in  = IN_W'(MAX_V);
    localparam logic signed [IN_W-1:0]  c_lo_in  = IN_W'(MIN_V);
    localparam logic signed [OUT_W-1:0] c_hi_out = OUT_W'(MAX_V);
    localparam logic signed [OUT_W-1:0] c_lo_out = OUT_W'(MIN_V);

    always_comb begin
        q_o = d_i[OUT_W-1:0];
        if (d_i > c_hi_in) begin
            q_o = c_hi_out;
        end else if (d_i < c_lo_in) begin
            q_o = c_lo_out;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ptch_pid_seq.sv
// ============================================================================
// Module  : ptch_pid_seq
// Brief   : Turns pitch samples into saturated P, I and D error terms.
//           Define PTCH_I_ANTIWINDUP_EN to hold the integrator on overflow.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ptch_pid_seq
    import seg_pkg::*;
#(
    parameter int D_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [PTCH_W-1:0]  ptch,
    input  logic                      vld,
    input  logic                      pwr_up,
    output logic                      busy,
    output logic signed [ERR_W-1:0]   ptch_err_sat,
    output logic signed [ERR_W-1:0]   ptch_err_I,
    output logic signed [DDIFF_W-1:0] ptch_D_diff_sat,
    output logic                      terms_vld
);

    pid_state_t                state_q;
    logic signed [PTCH_W-1:0]  sample_q;
    logic signed [ERR_W-1:0]   err_q;
    logic signed [INTEG_W-1:0] acc_q;
    logic signed [ERR_W-1:0]   hist_q [D_DEPTH];
    logic                      busy_q;
    logic                      terms_vld_q;
    logic signed [ERR_W-1:0]   err_out_q;
    logic signed [ERR_W-1:0]   i_out_q;
    logic signed [DDIFF_W-1:0] d_out_q;

    logic signed [ERR_W-1:0]   err_sat_d;
    logic signed [ERR_W:0]     diff_d;
    logic signed [DDIFF_W-1:0] diff_sat_d;
    logic signed [INTEG_W-1:0] err_ext_d;
    logic signed [INTEG_W-1:0] acc_sum_d;
    logic signed [INTEG_W-1:0] acc_d;

    sat_signed #(
        .IN_W  (PTCH_W),
        .OUT_W (ERR_W),
        .MAX_V (ERR_MAX),
        .MIN_V (ERR_MIN)
    ) u_err_sat (
        .d_i (sample_q),
        .q_o (err_sat_d)
    );

    // Extend by one bit so the difference of two 10-bit terms cannot wrap.
    assign diff_d = {err_q[ERR_W-1], err_q}
                  - {hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]};

    sat_signed #(
        .IN_W  (ERR_W + 1),
        .OUT_W (DDIFF_W),
        .MAX_V (DDIFF_MAX),
        .MIN_V (DDIFF_MIN)
    ) u_diff_sat (
        .d_i (diff_d),
        .q_o (diff_sat_d)
    );

    assign err_ext_d = {{(INTEG_W-ERR_W){err_q[ERR_W-1]}}, err_q};
    assign acc_sum_d = acc_q + err_ext_d;

`ifdef PTCH_I_ANTIWINDUP_EN
    logic ovf_d;
    assign ovf_d = (acc_q[INTEG_W-1] == err_ext_d[INTEG_W-1])
                && (acc_sum_d[INTEG_W-1] != acc_q[INTEG_W-1]);
    assign acc_d = ovf_d ? acc_q : acc_sum_d;
`else
    assign acc_d = acc_sum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            err_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            terms_vld_q <= 1'b0;
            err_out_q   <= '0;
            i_out_q     <= '0;
            d_out_q     <= '0;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    terms_vld_q <= 1'b0;
                    if (vld) begin
                        sample_q <= ptch;
                        state_q  <= SAT;
                        busy_q   <= 1'b1;
                    end
                end
                SAT: begin
                    err_q   <= err_sat_d;
                    state_q <= INTEG;
                end
                INTEG: begin
                    // Outputs are registered here so they appear with DONE.
                    acc_q       <= acc_d;
                    hist_q[0]   <= err_q;
                    for (int k = 1; k < D_DEPTH; k++) begin
                        hist_q[k] <= hist_q[k-1];
                    end
                    err_out_q   <= err_q;
                    i_out_q     <= pwr_up ? acc_d[INTEG_W-1 -: ERR_W] : '0;
                    d_out_q     <= diff_sat_d;
                    terms_vld_q <= 1'b1;
                    state_q     <= DONE;
                end
                default: begin
                    terms_vld_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase

            // Rider off: clear overrides any integrator/history update above.
            if (!pwr_up) begin
                acc_q <= '0;
                for (int k = 0; k < D_DEPTH; k++) begin
                    hist_q[k] <= '0;
                end
            end
        end
    end

    assign busy            = busy_q;
    assign terms_vld       = terms_vld_q;
    assign ptch_err_sat    = err_out_q;
    assign ptch_err_I      = i_out_q;
    assign ptch_D_diff_sat = d_out_q;

endmodule

`default_nettype wire

// File: doc/ptch_pid_seq.md
# ptch_pid_seq

Sequencer that turns raw pitch samples into the three saturated error terms consumed by the combinational `duty` block: `ptch_err_sat`, `ptch_err_I` and `ptch_D_diff_sat`. Sits between the inertial sensor interface and `duty`. On each accepted sample it:
- saturates the pitch error;
- updates a pitch-error integrator;
- computes a derivative against a history queue;
- presents the new term set with a one-cycle valid strobe.

## Interface
- `D_DEPTH`, default 2: derivative history depth in samples. Legal range 1–8.
- `clk`  in  1  system clock; all logic is clocked on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ptch`  in  16  signed pitch error sample.
- `vld`  in  1  new-sample strobe; sampled only in IDLE.
- `pwr_up`  in  1  rider-on enable. Low holds the integrator and history at 0.
- `busy`  out  1  high whenever state is not IDLE.
- `ptch_err_sat`  out  10  signed saturated error, to `duty`.
- `ptch_err_I`  out  10  signed integral term, to `duty`.
- `ptch_D_diff_sat`  out  7  signed saturated derivative, to `duty`.
- `terms_vld`  out  1  one-cycle pulse when all three outputs update.

## Operation
- FSM states: IDLE → SAT → INTEG → DONE → IDLE.
- IDLE:
  - `vld` = 1 captures `ptch` into a 16-bit register and moves to SAT.
  - `vld` = 0 stays in IDLE.
- SAT: clamps the captured sample to [-512, 511] into an internal `err` register, then moves to INTEG.
- INTEG:
  - `acc` (18-bit signed) ← `acc` + sign-extended `err`.
  - `diff` (11-bit) = `err` − `hist[D_DEPTH-1]`, clamped to [-64, 63].
  - History shifts: `hist[0]` ← `err`, `hist[k]` ← `hist[k-1]`.
  - Moves to DONE.
- DONE:
  - Output registers load `ptch_err_sat` = `err`, `ptch_err_I` = `acc[17:8]`, `ptch_D_diff_sat` = `diff`.
  - `terms_vld` = 1; moves to IDLE.
- Outputs hold their values between updates.
- `vld` in any non-IDLE state is dropped. There is no queueing.
- Integrator overflow is detected when both addends have the same sign and the sum's sign differs. Handling depends on configuration.
- `pwr_up` = 0:
  - `acc` and all `hist` entries are forced to 0 every cycle.
  - The sequence still runs, so `ptch_err_sat` and `ptch_D_diff_sat` are computed against a zero history, and `ptch_err_I` = 0.
- Reset values: state IDLE, `acc` 0, all `hist` 0, all outputs 0, `busy` 0, `terms_vld` 0.

## Timing
- Accepted `vld` at cycle N: `busy` is high for cycles N+1 to N+3. `terms_vld` and the new outputs appear at N+3.
- The earliest next accepted `vld` is at N+4, so maximum throughput is one sample per 4 cycles.
- `rst` mid-sequence: state returns to IDLE the next cycle with no `terms_vld`. All registers take their reset values.
- `pwr_up` falling mid-sequence: the INTEG update is overridden by the clear, and DONE reports `ptch_err_I` = 0.
- `vld` and `rst` asserted together: reset wins and the sample is dropped.

## Configuration
- `PTCH_I_ANTIWINDUP_EN` defined: on overflow, `acc` holds its previous value.
- `PTCH_I_ANTIWINDUP_EN` undefined: `acc` wraps using two's-complement arithmetic.

## Structure
- Shared package `seg_pkg` holds:
  - width constants: `PTCH_W` = 16, `ERR_W` = 10, `DDIFF_W` = 7, `INTEG_W` = 18;
  - the state enum `pid_state_t`;
  - saturation limits.
- One sub-module, `sat_signed`: a parameterized signed clamp (input width and output width). Two instances: error saturation and derivative saturation.

## Test plan
- Reset: after `rst`, all outputs 0, `busy` = 0, `terms_vld` = 0.
- Basic sample: `pwr_up` = 1, `ptch` = 100 with a 1-cycle `vld` from reset. Three cycles later `terms_vld` = 1, `ptch_err_sat` = 100, `ptch_err_I` = 0, `ptch_D_diff_sat` = 63.
- Saturation: `ptch` = 2000 gives `ptch_err_sat` = 511; `ptch` = −3000 gives `ptch_err_sat` = −512.
- Derivative queue (`D_DEPTH` = 2): three samples of `ptch` = 50 give `ptch_D_diff_sat` = 50, 50, 0. A fourth `vld` raised during `busy` is dropped and produces no `terms_vld`.
- Integrator limit: 256 samples of `ptch` = 511 give `acc` = 130816 and `ptch_err_I` = 511. One more sample then gives:
  - with `PTCH_I_ANTIWINDUP_EN`: `ptch_err_I` stays 511;
  - without it: `acc` = −130817 and `ptch_err_I` = −512.
- Power and reset interruption:
  - `pwr_up` dropped during INTEG: the next `terms_vld` shows `ptch_err_I` = 0.
  - `rst` during SAT: no `terms_vld`, and outputs read 0.
